// File: rtl/decoder_scan_pkg.sv
// ============================================================================
// Module  : decoder_scan_pkg
// Brief   : Shared state encoding and mode constants for decoder_scan.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_HOLD = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage : decoder_scan_pkg

`default_nettype wire

// File: rtl/decoder_nto2n.sv
// ============================================================================
// Module  : decoder_nto2n
// Brief   : Combinational N-to-2^N active-high one-hot decoder, all-0 when En=0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_nto2n #(
  parameter int N = 4
) (
  input  logic           En,
  input  logic [N-1:0]   W,
  output logic [0:2**N-1] Y
);

  always_comb begin
    Y = '0;
    if (En) begin
      Y[W] = 1'b1;
    end
  end

endmodule : decoder_nto2n

`default_nettype wire

// File: rtl/decoder_scan.sv
// ============================================================================
// Module  : decoder_scan
// Brief   : Registered N-to-2^N one-hot decoder with load/hold/scan sequencing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int N          = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            En,
  input  logic            Clear,
  input  logic            Load,
  input  logic            Mode,
  input  logic [N-1:0]    W,
  input  logic [N-1:0]    Last,
  output logic [0:2**N-1] Y,
  output logic [N-1:0]    Idx,
  output logic            Wrap
);

  localparam logic [0:2**N-1] c_INACTIVE = {(2**N){ACTIVE_LOW}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N-1:0]       r_idx;
  logic [N-1:0]       w_idx_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;
  logic [0:2**N-1]    r_y;
  logic [0:2**N-1]    w_dec;
  logic               w_dec_en;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      r_y     <= c_INACTIVE;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_wrap  <= w_wrap_nxt;
      r_y     <= w_dec ^ c_INACTIVE;
    end
  end

  // Wrap covers both the Last match and the natural 2^N-1 -> 0 rollover.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wrap_nxt  = 1'b0;
    if (Clear) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else if (Load) begin
      w_idx_nxt   = W;
      w_state_nxt = (Mode == MODE_SCAN) ? SCAN : HOLD;
    end else if ((r_state == SCAN) && En) begin
      w_idx_nxt  = (r_idx == Last) ? '0 : r_idx + N'(1);
      w_wrap_nxt = (w_idx_nxt == '0);
    end
  end

  assign w_dec_en = (w_state_nxt != IDLE) && En;

  decoder_nto2n #(
    .N (N)
  ) u_dec (
    .En (w_dec_en),
    .W  (w_idx_nxt),
    .Y  (w_dec)
  );

  assign Y    = r_y;
  assign Idx  = r_idx;
  assign Wrap = r_wrap;

endmodule : decoder_scan

`default_nettype wire

// File: tb/tb_decoder_scan.sv
// ============================================================================
// Module  : tb_decoder_scan
// Brief   : Self-checking bench for decoder_scan against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_scan;

  logic        clk = 1'b0;
  logic        rst, en, clr, ld, md;
  logic [3:0]  w, last;
  logic [0:15] y_al, y_ah;
  logic [3:0]  idx_al, idx_ah;
  logic        wrap_al, wrap_ah;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: 0 = idle, 1 = hold, 2 = scan
  int   m_st   = 0;
  int   m_idx  = 0;
  bit   m_wrap = 1'b0;
  logic [15:0] m_y_hi = 16'h0000;

  always #5 clk = ~clk;

  decoder_scan #(.N(4), .ACTIVE_LOW(1'b1)) dut (
    .Clock(clk), .Reset(rst), .En(en), .Clear(clr), .Load(ld), .Mode(md),
    .W(w), .Last(last), .Y(y_al), .Idx(idx_al), .Wrap(wrap_al)
  );

  decoder_scan #(.N(4), .ACTIVE_LOW(1'b0)) dut_ah (
    .Clock(clk), .Reset(rst), .En(en), .Clear(clr), .Load(ld), .Mode(md),
    .W(w), .Last(last), .Y(y_ah), .Idx(idx_ah), .Wrap(wrap_ah)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst || clr) begin
      m_st = 0; m_idx = 0; m_wrap = 1'b0;
    end else if (ld) begin
      m_idx = int'(w); m_st = md ? 2 : 1; m_wrap = 1'b0;
    end else if (m_st == 2 && en) begin
      m_idx  = (m_idx == int'(last)) ? 0 : (m_idx + 1) % 16;
      m_wrap = (m_idx == 0);
    end else begin
      m_wrap = 1'b0;
    end
    if (rst) m_y_hi = 16'h0000;
    else     m_y_hi = (m_st != 0 && en) ? (16'h8000 >> m_idx) : 16'h0000;
  endtask

  task automatic cyc(input bit i_rst, input bit i_en, input bit i_clr, input bit i_ld,
                     input bit i_md, input int i_w, input int i_last);
    rst = i_rst; en = i_en; clr = i_clr; ld = i_ld; md = i_md;
    w = i_w[3:0]; last = i_last[3:0];
    @(posedge clk);
    model_step();
    #1;
    check_eq("idx",     {28'd0, idx_al},  m_idx);
    check_eq("wrap",    {31'd0, wrap_al}, {31'd0, m_wrap});
    check_eq("y_al",    {16'd0, y_al},    {16'd0, ~m_y_hi});
    check_eq("y_ah",    {16'd0, y_ah},    {16'd0, m_y_hi});
    check_eq("idx_ah",  {28'd0, idx_ah},  m_idx);
    check_eq("wrap_ah", {31'd0, wrap_ah}, {31'd0, m_wrap});
  endtask

  initial begin
    int seq[7];
    seq = '{2, 3, 0, 1, 2, 3, 0};
    rst = 1'b1; en = 1'b0; clr = 1'b0; ld = 1'b0; md = 1'b0; w = '0; last = '0;

    // Reset and idle
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_eq("reset_y", {16'd0, y_al}, 32'h0000_FFFF);

    // HOLD load of 5
    cyc(0, 1, 0, 1, 0, 5, 0);
    check_eq("hold_y_al", {16'd0, y_al}, 32'h0000_FBFF);
    check_eq("hold_y_ah", {16'd0, y_ah}, 32'h0000_0400);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    check_eq("hold_idx", {28'd0, idx_al}, 32'd5);

    // SCAN with Last=3 starting at 2
    cyc(0, 1, 0, 1, 1, 2, 3);
    check_eq("scan_seq0", {28'd0, idx_al}, seq[0]);
    for (int i = 1; i < 7; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 3);
      check_eq("scan_seq", {28'd0, idx_al}, seq[i]);
      check_eq("scan_wrap", {31'd0, wrap_al}, (seq[i] == 0) ? 1 : 0);
    end

    // En gating around Idx=1
    cyc(0, 1, 0, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 3);
      check_eq("gap_y", {16'd0, y_al}, 32'h0000_FFFF);
      check_eq("gap_idx", {28'd0, idx_al}, 32'd1);
    end
    cyc(0, 1, 0, 0, 0, 0, 3);
    cyc(0, 1, 0, 0, 0, 0, 3);

    // Clear beats Load; Load during SCAN
    cyc(0, 1, 1, 1, 1, 9, 3);
    check_eq("clr_y", {16'd0, y_al}, 32'h0000_FFFF);
    cyc(0, 1, 0, 1, 1, 3, 3);
    cyc(0, 1, 0, 1, 1, 9, 3);
    check_eq("ld_scan_idx", {28'd0, idx_al}, 32'd9);
    check_eq("ld_scan_wrap", {31'd0, wrap_al}, 32'd0);

    // Overrange start above Last
    cyc(0, 1, 0, 1, 1, 14, 2);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0, 2);

    // Last=0 pins Idx at 0 with Wrap every enabled cycle
    cyc(0, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      check_eq("last0_wrap", {31'd0, wrap_al}, 32'd1);
    end

    // Last=15 full count and reset mid-scan
    cyc(0, 1, 0, 1, 1, 13, 15);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 15);
    cyc(1, 1, 0, 0, 0, 0, 15);
    check_eq("midrst_y", {16'd0, y_al}, 32'h0000_FFFF);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_decoder_scan

`default_nettype wire
